// File: rtl/servo_timing_pkg.sv
// Timing constants shared by the servo PWM generator and the servo pulse decoder.
// All values are in system-clock cycles.
package servo_timing_pkg;

  localparam int FRAME_CYC  = 240000;
  localparam int POS_OPEN   = 27000;
  localparam int POS_CLOSED = 77000;
  localparam int CNT_W      = 18;

  // Pin-to-strobe latency of sync_edge_detect; edges are only trusted after this many cycles.
  localparam int SYNC_LAT   = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, with registered rise/fall strobes.
// level_o is delayed so that it lines up with the strobes.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures high time and period of a servo pulse train, qualifies the width,
// decodes the door-lock state and flags out-of-range pulses and loss of signal.
module servo_pulse_decoder #(
  parameter int CNT_W     = servo_timing_pkg::CNT_W,
  parameter int MIN_WIDTH = 20000,
  parameter int MAX_WIDTH = 90000,
  parameter int THRESH    = 52000,
  parameter int TIMEOUT   = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             door_open,
  output logic             err_range,
  output logic             err_timeout,
  output logic             signal_lost
);

  import servo_timing_pkg::*;

  typedef enum logic [1:0] {
    S_ARM       = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PRIME = CNT_W'(SYNC_LAT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  logic level, rise, fall;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(pwm_in),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] pulse_width_q, pulse_width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             door_open_q, door_open_d;
  logic             valid_q, valid_d;
  logic             err_range_q, err_range_d;
  logic             err_timeout_q, err_timeout_d;
  logic             signal_lost_q, signal_lost_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ARM;
      width_cnt_q   <= '0;
      period_cnt_q  <= '0;
      idle_cnt_q    <= '0;
      pulse_width_q <= '0;
      period_q      <= '0;
      door_open_q   <= 1'b0;
      valid_q       <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      signal_lost_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_cnt_q   <= width_cnt_d;
      period_cnt_q  <= period_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      pulse_width_q <= pulse_width_d;
      period_q      <= period_d;
      door_open_q   <= door_open_d;
      valid_q       <= valid_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    width_cnt_d   = width_cnt_q;
    period_cnt_d  = period_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    pulse_width_d = pulse_width_q;
    period_d      = period_q;
    door_open_d   = door_open_q;
    valid_d       = 1'b0;
    err_range_d   = 1'b0;
    err_timeout_d = 1'b0;
    signal_lost_d = signal_lost_q;

    unique case (state_q)
      S_ARM: begin
        // The sync flops read 0 right after reset; only trust "low" once they hold real pin data.
        if (!level && (idle_cnt_q >= PRIME)) begin
          state_d    = S_WAIT_RISE;
          idle_cnt_d = ONE;
        end else if (idle_cnt_q == TO_C) begin
          err_timeout_d = 1'b1;
          signal_lost_d = 1'b1;
          idle_cnt_d    = ONE;
        end else begin
          idle_cnt_d = sat_inc(idle_cnt_q);
        end
      end

      S_WAIT_RISE: begin
        if (rise) begin
          state_d      = S_HIGH;
          width_cnt_d  = ONE;
          period_cnt_d = ONE;
        end else if (idle_cnt_q == TO_C) begin
          err_timeout_d = 1'b1;
          signal_lost_d = 1'b1;
          idle_cnt_d    = ONE;
        end else begin
          idle_cnt_d = sat_inc(idle_cnt_q);
        end
      end

      S_HIGH: begin
        // The fall cycle still belongs to the period but not to the width.
        if (fall) begin
          state_d      = S_LOW;
          period_cnt_d = sat_inc(period_cnt_q);
          if ((width_cnt_q >= MIN_C) && (width_cnt_q <= MAX_C)) begin
            pulse_width_d = width_cnt_q;
            door_open_d   = (width_cnt_q < THR_C);
            valid_d       = 1'b1;
            signal_lost_d = 1'b0;
          end else begin
            err_range_d = 1'b1;
          end
        end else if (width_cnt_q == TO_C) begin
          err_timeout_d = 1'b1;
          signal_lost_d = 1'b1;
          state_d       = S_ARM;
          idle_cnt_d    = ONE;
        end else begin
          width_cnt_d  = sat_inc(width_cnt_q);
          period_cnt_d = sat_inc(period_cnt_q);
        end
      end

      S_LOW: begin
        if (rise) begin
          period_d     = period_cnt_q;
          width_cnt_d  = ONE;
          period_cnt_d = ONE;
          state_d      = S_HIGH;
        end else if (period_cnt_q == TO_C) begin
          err_timeout_d = 1'b1;
          signal_lost_d = 1'b1;
          state_d       = S_WAIT_RISE;
          idle_cnt_d    = ONE;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
        end
      end

      default: state_d = S_ARM;
    endcase
  end

  assign pulse_width = pulse_width_q;
  assign period      = period_q;
  assign valid       = valid_q;
  assign door_open   = door_open_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with timing scaled down by 100
// (MIN 200, MAX 900, THRESH 520, TIMEOUT 2500, frames of 2400 cycles).
module tb_servo_pulse_decoder;

  localparam int CW = 18;

  logic          clk;
  logic          rst_n;
  logic          pwm_in;
  logic [CW-1:0] pulse_width;
  logic [CW-1:0] period;
  logic          valid;
  logic          door_open;
  logic          err_range;
  logic          err_timeout;
  logic          signal_lost;

  servo_pulse_decoder #(
    .CNT_W    (CW),
    .MIN_WIDTH(200),
    .MAX_WIDTH(900),
    .THRESH   (520),
    .TIMEOUT  (2500)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .pulse_width(pulse_width),
    .period     (period),
    .valid      (valid),
    .door_open  (door_open),
    .err_range  (err_range),
    .err_timeout(err_timeout),
    .signal_lost(signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe-high cycles; a stretched strobe shows up as an extra count.
  int valid_tot = 0;
  int range_tot = 0;
  int to_tot    = 0;

  always @(negedge clk) begin
    if (valid)       valid_tot++;
    if (err_range)   range_tot++;
    if (err_timeout) to_tot++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int v0, r0, t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int hi, input int per);
    pwm_in = 1'b1;
    cyc(hi);
    pwm_in = 1'b0;
    cyc(per - hi);
  endtask

  task automatic snap();
    v0 = valid_tot;
    r0 = range_tot;
    t0 = to_tot;
  endtask

  task automatic chk_counts(input string tag, input int ev, input int er, input int et);
    chk({tag, "_valid"},   valid_tot - v0, ev);
    chk({tag, "_errrng"},  range_tot - r0, er);
    chk({tag, "_timeout"}, to_tot - t0,    et);
  endtask

  task automatic chk_out(input string tag, input int pw, input int dr, input int per, input int lost);
    chk({tag, "_width"},  pulse_width, pw);
    chk({tag, "_door"},   door_open,   dr);
    chk({tag, "_period"}, period,      per);
    chk({tag, "_lost"},   signal_lost, lost);
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    cyc(3);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_valid",   valid,       0);
    chk("reset_errrng",  err_range,   0);
    chk("reset_timeout", err_timeout, 0);
    rst_n = 1'b1;
    cyc(10);

    // Open-position frames
    snap();
    frame(270, 2400);
    chk_counts("t1a", 1, 0, 0);
    chk_out("t1a", 270, 1, 0, 0);
    frame(270, 2400);
    frame(270, 2400);
    chk_counts("t1b", 3, 0, 0);
    chk_out("t1b", 270, 1, 2400, 0);

    // Closed-position frames, second one with a shorter period
    snap();
    frame(770, 2300);
    chk_counts("t2a", 1, 0, 0);
    chk_out("t2a", 770, 0, 2400, 0);
    frame(770, 2400);
    chk_out("t2b", 770, 0, 2300, 0);

    // Out-of-range widths hold the last legal decode
    snap();
    frame(100, 2400);
    chk_counts("t3a", 0, 1, 0);
    chk_out("t3a", 770, 0, 2400, 0);
    frame(950, 2400);
    chk_counts("t3b", 0, 2, 0);
    chk_out("t3b", 770, 0, 2400, 0);

    // Width and threshold boundaries
    snap();
    frame(200, 2400);
    chk("b200_width", pulse_width, 200);
    chk("b200_door",  door_open,   1);
    frame(199, 2400);
    chk("b199_errrng", range_tot - r0, 1);
    chk("b199_width",  pulse_width,    200);
    frame(900, 2400);
    chk("b900_width", pulse_width, 900);
    chk("b900_door",  door_open,   0);
    frame(901, 2400);
    chk("b901_errrng", range_tot - r0, 2);
    chk("b901_width",  pulse_width,    900);
    frame(519, 2400);
    chk("b519_width", pulse_width, 519);
    chk("b519_door",  door_open,   1);
    frame(520, 2400);
    chk("b520_width", pulse_width, 520);
    chk("b520_door",  door_open,   0);
    chk_counts("bnd", 4, 2, 0);

    // Signal held low: one timeout, then another once the idle counter restarts
    snap();
    cyc(2000);
    chk_counts("t4a", 0, 0, 1);
    chk("t4a_lost", signal_lost, 1);
    cyc(1000);
    chk("t4b_timeout", to_tot - t0, 2);
    snap();
    frame(270, 2400);
    chk_counts("t4c", 1, 0, 0);
    chk_out("t4c", 270, 1, 2400, 0);

    // Pin already high at reset release
    rst_n  = 1'b0;
    pwm_in = 1'b1;
    cyc(3);
    chk_out("t5rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    snap();
    cyc(2600);
    chk_counts("t5a", 0, 0, 1);
    chk("t5a_lost",  signal_lost, 1);
    chk("t5a_width", pulse_width, 0);
    pwm_in = 1'b0;
    cyc(20);
    frame(270, 2400);
    chk_counts("t5b", 1, 0, 1);
    chk_out("t5b", 270, 1, 0, 0);

    // Reset in the middle of a pulse
    snap();
    pwm_in = 1'b1;
    cyc(150);
    rst_n = 1'b0;
    #1;
    chk("t6rst_width", pulse_width, 0);
    chk("t6rst_door",  door_open,   0);
    cyc(3);
    rst_n = 1'b1;
    cyc(100);
    pwm_in = 1'b0;
    cyc(500);
    frame(770, 2400);
    frame(770, 2400);
    chk_counts("t6", 2, 0, 0);
    chk_out("t6", 770, 0, 2400, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
